hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Central pipeline sequencing controller for the 5-stage RV64 core.
- Decides every cycle which stage registers advance, hold or flush:
  - load-use stall: IF/ID source registers against the ID/EX load destination.
  - taken-branch flush: branch resolved in EX/MEM.
  - multi-cycle data-memory wait: full freeze.
- Sits beside the IF/ID decode path (immediate extraction, register read) and drives the PC and pipeline-register enables/clears.
- Keeps saturating stall and flush performance counters.

Parameters:
- REDIRECT_LAT, 1, extra cycles IF/ID stays flushed after a taken branch (instruction-fetch latency of the redirect); range 0-7.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- ifid_inst  in  32  instruction in IF/ID.
- ifid_valid  in  1  IF/ID holds a real instruction.
- idex_memread  in  1  instruction in ID/EX is a load.
- idex_rd  in  5  destination register of the ID/EX instruction.
- exmem_branch_taken  in  1  branch/jump in EX/MEM resolved taken.
- mem_req  in  1  EX/MEM instruction accesses data memory this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID synchronous clear to bubble.
- idex_flush  out  1  ID/EX clear to bubble (control fields zeroed).
- exmem_flush  out  1  EX/MEM clear to bubble.
- pipe_freeze  out  1  all of ID/EX, EX/MEM, MEM/WB hold.
- stall_count  out  CNT_W  cycles with pc_write=0, saturating.
- flush_count  out  CNT_W  taken-branch redirects, saturating.

Behaviour:
- Decode of ifid_inst:
  - rs1 = [19:15]; rs2 = [24:20]; opcode = [6:0].
  - uses_rs1 for all opcodes except 0110111 (LUI), 0010111 (AUIPC) and 1101111 (JAL).
  - uses_rs2 only for 0110011 (R), 0100011 (S) and 1100011 (B).
- load_use = ifid_valid & idex_memread & (idex_rd != 0) & ((uses_rs1 & rs1 == idex_rd) | (uses_rs2 & rs2 == idex_rd)).
- mem_stall = mem_req & ~mem_ready.
- FSM states: RUN, MEM_WAIT, FLUSH. Held in a register; outputs are combinational from state plus inputs, so a hazard is acted on in the cycle it is detected.
- Priority within any state: mem_stall > exmem_branch_taken > FLUSH countdown > load_use.
- RUN:
  - mem_stall: pipe_freeze=1, pc_write=0, ifid_write=0, no flushes; next state MEM_WAIT.
  - else exmem_branch_taken: pc_write=1 (target), ifid_write=1, ifid_flush=idex_flush=exmem_flush=1, flush_count++; next state FLUSH if REDIRECT_LAT>0 (load redir_cnt=REDIRECT_LAT), else RUN.
  - else load_use: pc_write=0, ifid_write=0, idex_flush=1 for exactly one cycle; next state RUN. The bubble in ID/EX clears the hazard the following cycle.
  - else: pc_write=1, ifid_write=1, all flushes 0.
- MEM_WAIT:
  - Freeze outputs as above while mem_stall.
  - On the mem_ready cycle, outputs follow the RUN rules.
  - Next state is RUN, or FLUSH if redir_cnt != 0 was saved on entry.
- FLUSH:
  - pc_write=0, ifid_write=1, ifid_flush=1; redir_cnt--. Return to RUN when it reaches 1.
  - load_use is ignored, since IF/ID is discarded.
  - mem_stall freezes and holds redir_cnt.
  - exmem_branch_taken in FLUSH is a don't-care (EX/MEM holds a bubble). The design ignores it; the bench asserts it never occurs.
- exmem_branch_taken is sampled only when not frozen.
- Counters:
  - stall_count increments on every cycle with pc_write=0 and reset deasserted.
  - Both counters saturate at all-ones; they never wrap.
- Reset (asynchronous, any time including mid-stall or mid-flush):
  - state=RUN, redir_cnt=0, both counters 0.
  - While reset=0, outputs are forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, exmem_flush=1, pipe_freeze=0.
  - First cycle after release: normal RUN outputs.

Decomposition:
- Shared package core_pkg:
  - opcode localparams: OP_R, OP_I_ALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
  - state enum ctrl_state_t {RUN, MEM_WAIT, FLUSH}.
  - REG_ADDR_W=5.
- Sub-module: reg_use_decode (inst → rs1, rs2, uses_rs1, uses_rs2), reusable by the forwarding unit.

Test Plan:
- Load-use: ID/EX `ld x5` (idex_memread=1, idex_rd=5), IF/ID `add x6,x5,x7` → exactly 1 cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_count=1; next cycle pc_write=1.
- No false stall:
  - IF/ID `lui x5,0x1` with ID/EX load to x5 → no stall.
  - ID/EX load to x0, IF/ID `add x1,x0,x0` → no stall.
  - IF/ID `addi x6,x9,1` with ID/EX load to x9 → stall (rs1 only).
- Taken branch, REDIRECT_LAT=2: all three flushes for 1 cycle, then 2 cycles of ifid_flush=1 with pc_write=0; flush_count=1; stall_count=2.
- Memory wait: mem_req=1, mem_ready low for 4 cycles → pipe_freeze=1 for 4 cycles, stall_count=4. A simultaneous load_use is not acted on until the freeze ends.
- Simultaneous branch_taken and load_use in RUN → flush wins; idex_flush=1, pc_write=1; no load-use stall cycle counted.
- Reset asserted mid-FLUSH (redir_cnt=1) → immediate flush outputs; after release state RUN, counters 0, pc_write=1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the RV64 core: opcodes, register-address width and
// the pipeline sequencing controller state.
package core_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    FLUSH
  } ctrl_state_t;

endpackage

// File: rtl/reg_use_decode.sv
// Extracts source register fields from an RV64 instruction and reports which
// of them the instruction actually reads. Shared with the forwarding unit.
module reg_use_decode
  import core_pkg::*;
(
  input  logic [31:0]           inst,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic                  uses_rs1,
  output logic                  uses_rs2
);

  logic [6:0] opcode;
  logic       unused_fields;

  assign opcode        = inst[6:0];
  assign rs1           = inst[19:15];
  assign rs2           = inst[24:20];
  assign unused_fields = ^{inst[31:25], inst[14:7]};

  // NOTE: both outputs get a default before the case so no latch is inferred.
  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL:   uses_rs1 = 1'b0;
      OP_R, OP_STORE, OP_BRANCH:  uses_rs2 = 1'b1;
      default:                    ;
    endcase
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stall, taken-branch flush and
// data-memory freeze, plus saturating stall/flush performance counters.
module hazard_stall_ctrl
  import core_pkg::*;
#(
  parameter int unsigned REDIRECT_LAT = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           ifid_inst,
  input  logic                  ifid_valid,
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  exmem_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  pipe_freeze,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int unsigned        RC_W       = 3;
  localparam logic [RC_W-1:0]    REDIR_INIT = RC_W'(REDIRECT_LAT);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  logic [REG_ADDR_W-1:0] rs1, rs2;
  logic                  uses_rs1, uses_rs2;
  logic                  load_use, mem_stall, redirect;

  ctrl_state_t           state, state_nxt;
  logic [RC_W-1:0]       redir_cnt, redir_cnt_nxt;

  reg_use_decode u_decode (
    .inst     (ifid_inst),
    .rs1      (rs1),
    .rs2      (rs2),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  assign load_use  = ifid_valid & idex_memread & (idex_rd != '0) &
                     ((uses_rs1 & (rs1 == idex_rd)) | (uses_rs2 & (rs2 == idex_rd)));
  assign mem_stall = mem_req & ~mem_ready;

  // Outputs are decoded from the current state and live inputs so a hazard
  // takes effect in the same cycle it appears.
  always_comb begin
    state_nxt     = state;
    redir_cnt_nxt = redir_cnt;
    redirect      = 1'b0;
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    pipe_freeze   = 1'b0;

    if (!reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (mem_stall) begin
      pipe_freeze = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      // A freeze during the redirect shadow keeps the remaining count in FLUSH.
      if (state != FLUSH) state_nxt = MEM_WAIT;
    end else if (state == FLUSH) begin
      pc_write   = 1'b0;
      ifid_flush = 1'b1;
      if (redir_cnt <= RC_W'(1)) begin
        redir_cnt_nxt = '0;
        state_nxt     = RUN;
      end else begin
        redir_cnt_nxt = redir_cnt - RC_W'(1);
      end
    end else if (exmem_branch_taken) begin
      redirect    = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      if (REDIRECT_LAT > 0) begin
        state_nxt     = FLUSH;
        redir_cnt_nxt = REDIR_INIT;
      end else begin
        state_nxt = RUN;
      end
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      state_nxt  = RUN;
    end else begin
      state_nxt = RUN;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      redir_cnt   <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state     <= state_nxt;
      redir_cnt <= redir_cnt_nxt;
      if (!pc_write && (stall_count != CNT_MAX)) stall_count <= stall_count + CNT_W'(1);
      if (redirect && (flush_count != CNT_MAX))  flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule
